// File: rtl/cve2_gpio_in.sv
// cve2_gpio_in: board input peripheral for the CVE2 SoC.
//   Synchronizes and debounces gpio_i, latches rising (and optionally falling)
//   edge events, exposes them over a req/gnt/rvalid data-bus slave and raises
//   a level interrupt for enabled events.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   gpio_i            asynchronous board inputs
//   req_i/we_i        bus request / write strobe (gnt_o = req_i)
//   addr_i[3:2]       0 DATA (ro), 1 RISE (w1c), 2 IRQ_EN (rw), 3 FALL (w1c)
//   be_i/wdata_i      byte enables / write data
//   rvalid_o/rdata_o  one-cycle response; rdata_o is 0 outside read responses
//   irq_o             |(rise & irq_en) [| |(fall & irq_en)]
// Optional feature: define CVE2_GPIO_FALL_EDGE_EN to build the FALL register.

// Per-input synchronizer, debounce counter and edge pulses.
module cve2_gpio_in_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + 1'b1;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= gpio_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Edge pulses are taken from stable_d so the event flop sets on the same
  // edge that stable changes; this is what lets set beat a coincident W1C.
  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;
  assign fall_o   = ~stable_d & stable_q;
endmodule

module cve2_gpio_in #(
  parameter int unsigned N_INPUTS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_INPUTS-1:0] gpio_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [3:0]          addr_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                irq_o
);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RISE = 2'd1;
  localparam logic [1:0] A_EN   = 2'd2;
  localparam logic [1:0] A_FALL = 2'd3;

  logic [N_INPUTS-1:0] stable, rise_set, fall_set;
  logic [N_INPUTS-1:0] rise_q, rise_d, en_q, en_d;
  logic [31:0]         wmask, rd_val, rdata_q;
  logic [N_INPUTS-1:0] wbits;
  logic                wr_acc, rd_acc, rvalid_q;

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_lane
    cve2_gpio_in_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .gpio_i   (gpio_i[i]),
      .stable_o (stable[i]),
      .rise_o   (rise_set[i]),
      .fall_o   (fall_set[i])
    );
  end

  assign wmask  = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign wbits  = wdata_i[N_INPUTS-1:0] & wmask[N_INPUTS-1:0];
  assign wr_acc = req_i & we_i;
  assign rd_acc = req_i & ~we_i;

`ifdef CVE2_GPIO_FALL_EDGE_EN
  logic [N_INPUTS-1:0] fall_q, fall_d;
`endif

  always_comb begin
    en_d = en_q;
    if (wr_acc && addr_i[3:2] == A_EN) en_d = (en_q & ~wmask[N_INPUTS-1:0]) | wbits;
    // Set is OR-ed after the clear so a coincident event wins.
    rise_d = rise_q;
    if (wr_acc && addr_i[3:2] == A_RISE) rise_d = rise_q & ~wbits;
    rise_d = rise_d | rise_set;
`ifdef CVE2_GPIO_FALL_EDGE_EN
    fall_d = fall_q;
    if (wr_acc && addr_i[3:2] == A_FALL) fall_d = fall_q & ~wbits;
    fall_d = fall_d | fall_set;
`endif
  end

  always_comb begin
    rd_val = '0;
    case (addr_i[3:2])
      A_DATA: rd_val = 32'(stable);
      A_RISE: rd_val = 32'(rise_q);
      A_EN:   rd_val = 32'(en_q);
`ifdef CVE2_GPIO_FALL_EDGE_EN
      A_FALL: rd_val = 32'(fall_q);
`endif
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q   <= '0;
      en_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef CVE2_GPIO_FALL_EDGE_EN
      fall_q   <= '0;
`endif
    end else begin
      rise_q   <= rise_d;
      en_q     <= en_d;
      rvalid_q <= req_i;
      rdata_q  <= rd_acc ? rd_val : '0;
`ifdef CVE2_GPIO_FALL_EDGE_EN
      fall_q   <= fall_d;
`endif
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

`ifdef CVE2_GPIO_FALL_EDGE_EN
  assign irq_o = |(rise_q & en_q) | |(fall_q & en_q);
  logic unused_bits;
  assign unused_bits = ^{wdata_i, wmask, addr_i[1:0]};
`else
  assign irq_o = |(rise_q & en_q);
  logic unused_bits;
  assign unused_bits = ^{wdata_i, wmask, addr_i[1:0], fall_set};
`endif
endmodule

// File: tb/tb_cve2_gpio_in.sv
module tb_cve2_gpio_in;
`ifdef CVE2_GPIO_FALL_EDGE_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  gpio_i = '0;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [3:0]  addr_i = '0, be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, irq_o;
  logic [31:0] rdata_o;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  logic [31:0] sb_q[$];

  cve2_gpio_in #(.N_INPUTS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .gpio_i(gpio_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: each accepted request pushes its expected response at the
  // accept edge; the following negedge must show exactly that response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0) begin
        logic [31:0] e;
        e = sb_q.pop_front();
        chk("rvalid", {31'd0, rvalid_o}, 32'd1);
        chk("rdata", rdata_o, e);
      end else begin
        chk("rvalid_idle", {31'd0, rvalid_o}, 32'd0);
        chk("rdata_idle", rdata_o, 32'd0);
      end
    end
  end

  task automatic rd(input logic [3:0] a, input logic [31:0] exp);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 4'h0; wdata_i = '0;
    @(posedge clk);
    sb_q.push_back(exp);
    #1 req_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; be_i = be; wdata_i = d;
    @(posedge clk);
    sb_q.push_back(32'd0);
    #1 req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset with inputs high and req toggling
    rst = 1'b1; gpio_i = 4'hF; req_i = 1'b1;
    #1 chk("gnt_follow1", {31'd0, gnt_o}, 32'd1);
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    req_i = 1'b0;
    #1 chk("gnt_follow0", {31'd0, gnt_o}, 32'd0);
    @(posedge clk); #1;
    req_i = 1'b1;
    @(posedge clk); #1;             // request in a reset cycle: no response
    req_i = 1'b0; rst = 1'b0;
    rd(4'h0, 32'h0);
    gpio_i = 4'h0;
    idle(10);

    // 2. debounce latency: new level before edge k, DATA changes at k+5
    gpio_i[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rd(4'h0, 32'h0);                // accepted at k+5, samples pre-edge value
    rd(4'h0, 32'h1);                // accepted at k+6
    rd(4'h4, 32'h1);
    chk("irq_no_en", {31'd0, irq_o}, 32'd0);
    // 3-cycle glitch on bit1 must be swallowed
    gpio_i[1] = 1'b1;
    idle(3);
    gpio_i[1] = 1'b0;
    idle(10);

    // 3. back-to-back reads, 0xC, byte enables
    rd(4'h0, 32'h1);
    rd(4'h4, 32'h1);
    rd(4'h8, 32'h0);
    rd(4'hC, 32'h0);
    wr(4'h8, 4'h0, 32'h5);
    rd(4'h8, 32'h0);
    wr(4'h8, 4'h1, 32'h5);
    rd(4'h8, 32'h5);
    wr(4'hB, 4'hF, 32'hFFFF_FFFF);  // low address bits ignored, upper bits dropped
    rd(4'h8, 32'hF);
    wr(4'h0, 4'hF, 32'hF);          // DATA is read-only
    rd(4'h0, 32'h1);

    // 4. interrupt + W1C
    wr(4'h8, 4'hF, 32'h1);
    chk("irq_en_set", {31'd0, irq_o}, 32'd1);
    wr(4'h4, 4'h2, 32'h1);          // wrong byte lane: no clear
    chk("irq_be_keep", {31'd0, irq_o}, 32'd1);
    rd(4'h4, 32'h1);
    wr(4'h4, 4'h1, 32'h1);
    chk("irq_w1c", {31'd0, irq_o}, 32'd0);
    rd(4'h4, 32'h0);
    gpio_i[0] = 1'b0;
    idle(10);
    chk("irq_after_fall", {31'd0, irq_o}, {31'd0, FALL_EN});
    if (FALL_EN) wr(4'hC, 4'hF, 32'h1);
    gpio_i[0] = 1'b1;
    idle(10);
    chk("irq_new_rise", {31'd0, irq_o}, 32'd1);
    rd(4'h4, 32'h1);
    wr(4'h4, 4'hF, 32'h1);
    chk("irq_clr2", {31'd0, irq_o}, 32'd0);

    // 5. set wins over a W1C in the same edge
    gpio_i[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    wr(4'h4, 4'hF, 32'h4);          // accepted at the edge stable[2] rises
    rd(4'h4, 32'h4);
    rd(4'h0, 32'h5);
    chk("irq_bit2_masked", {31'd0, irq_o}, 32'd0);
    wr(4'h4, 4'hF, 32'h4);
    rd(4'h4, 32'h0);

    // 6. falling edge on bit3
    wr(4'h8, 4'hF, 32'h8);
    gpio_i[3] = 1'b1;
    idle(8);
    chk("irq_rise3", {31'd0, irq_o}, 32'd1);
    wr(4'h4, 4'hF, 32'h8);
    chk("irq_rise3_clr", {31'd0, irq_o}, 32'd0);
    gpio_i[3] = 1'b0;
    idle(8);
    chk("irq_fall3", {31'd0, irq_o}, {31'd0, FALL_EN});
    rd(4'hC, FALL_EN ? 32'h8 : 32'h0);
    wr(4'hC, 4'hF, 32'h8);
    chk("irq_fall3_clr", {31'd0, irq_o}, 32'd0);
    rd(4'hC, 32'h0);

    // reset mid-transaction drops the pending response
    req_i = 1'b1; we_i = 1'b0; addr_i = 4'h0; rst = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_irq2", {31'd0, irq_o}, 32'd0);
    rd(4'h8, 32'h0);
    rd(4'h0, 32'h0);
    idle(3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
